// File: rtl/axis_preload_ctrl.sv
// -----------------------------------------------------------------------------
// axis_preload_ctrl
//   Sequencer for the AXI-Stream ifmap preload FIFO. It accepts one tile of
//   packed 6-channel beats, drives the FIFO load/read/clear strobes and hands
//   complete rows to the MAC array on request. It keeps a row-accurate copy of
//   the FIFO packing rule, so it never loads into a full FIFO and never reads
//   a partially written row.
//
// Ports
//   clk, rst               clock, asynchronous active-high reset
//   start, abort           tile start pulse (IDLE only) / tile cancel
//   input_channel_size     channels per row, latched on accepted start
//   row_num                rows in the tile, latched on accepted start
//   s_axis_tvalid/tlast    stream beat valid / end-of-tile marker
//   s_axis_tready          beat accepted when high together with tvalid
//   fifo_cnt/full/empty    FIFO status (complete rows only)
//   load_axis_preload      FIFO write strobe
//   fifo_read              FIFO pop strobe
//   axis_clear             FIFO pointer/count clear
//   mac_req, mac_row_fire  MAC row request / row consumed this cycle
//   busy, done, tlast_err  not idle / tile-complete pulse / sticky tlast error
// -----------------------------------------------------------------------------
module axis_preload_ctrl #(
  parameter int AXIS_PRELOAD_FIFO_DEPTH = 4,
  parameter int CNT_W                   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [11:0]      input_channel_size,
  input  logic [11:0]      row_num,
  input  logic             s_axis_tvalid,
  input  logic             s_axis_tlast,
  output logic             s_axis_tready,
  input  logic [CNT_W-1:0] fifo_cnt,
  input  logic             fifo_full,
  input  logic             fifo_empty,
  output logic             load_axis_preload,
  output logic             fifo_read,
  output logic             axis_clear,
  input  logic             mac_req,
  output logic             mac_row_fire,
  output logic             busy,
  output logic             done,
  output logic             tlast_err
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_RUN   = 3'd2,
    S_DONE  = 3'd3,
    S_ABORT = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [11:0] ics_q, ics_d;
  logic [11:0] rows_q, rows_d;
  logic [8:0]  ch_cnt_q, ch_cnt_d;
  logic [11:0] rows_loaded_q, rows_loaded_d;
  logic [11:0] rows_read_q, rows_read_d;
  logic        tlast_err_q, tlast_err_d;

  logic        run_st;
  logic        start_acc;
  logic        full_eff, empty_eff;
  logic [12:0] ch_plus6;
  logic        row_end;
  logic        last_row;
  logic        exp_tlast;
  logic        last_read;

  // The count is folded into full/empty as a second opinion; with a
  // consistent FIFO the flags alone decide.
  assign full_eff  = fifo_full  | (fifo_cnt >= CNT_W'(AXIS_PRELOAD_FIFO_DEPTH));
  assign empty_eff = fifo_empty | (fifo_cnt == '0);

  assign start_acc = (state_q == S_IDLE) & start;

  // Row packing: a beat closes the row once 6 more channels would pass ics.
  assign ch_plus6  = {4'd0, ch_cnt_q} + 13'd6;
  assign row_end   = ch_plus6 > {1'b0, ics_q};
  assign last_row  = ({1'b0, rows_loaded_q} + 13'd1) == {1'b0, rows_q};
  assign exp_tlast = row_end & last_row;
  assign last_read = ({1'b0, rows_read_q} + 13'd1) == {1'b0, rows_q};

  assign s_axis_tready     = run_st & (rows_loaded_q < rows_q) & ~full_eff;
  assign load_axis_preload = s_axis_tvalid & s_axis_tready;
  assign fifo_read         = run_st & mac_req & ~empty_eff & (rows_read_q < rows_q);
  assign mac_row_fire      = fifo_read;
  assign tlast_err         = tlast_err_q;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; abort outranks every other exit
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_CLEAR;
      S_CLEAR: if (abort)               state_d = S_ABORT;
               else if (rows_q == '0)   state_d = S_DONE;
               else                     state_d = S_RUN;
      S_RUN:   if (abort)                       state_d = S_ABORT;
               else if (fifo_read && last_read) state_d = S_DONE;
      S_DONE:  state_d = abort ? S_ABORT : S_IDLE;
      S_ABORT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    run_st     = 1'b0;
    axis_clear = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state_q)
      S_IDLE:  busy       = 1'b0;
      S_CLEAR: axis_clear = 1'b1;
      S_RUN:   run_st     = 1'b1;
      S_DONE:  done       = 1'b1;
      S_ABORT: axis_clear = 1'b1;
      default: busy       = 1'b0;
    endcase
  end

  // Tile counters and sticky error
  always_comb begin
    ics_d         = ics_q;
    rows_d        = rows_q;
    ch_cnt_d      = ch_cnt_q;
    rows_loaded_d = rows_loaded_q;
    rows_read_d   = rows_read_q;
    tlast_err_d   = tlast_err_q;
    if (start_acc) begin
      ics_d         = input_channel_size;
      rows_d        = row_num;
      ch_cnt_d      = '0;
      rows_loaded_d = '0;
      rows_read_d   = '0;
      tlast_err_d   = 1'b0;
    end else begin
      if (load_axis_preload) begin
        if (row_end) begin
          ch_cnt_d      = '0;
          rows_loaded_d = rows_loaded_q + 12'd1;
        end else begin
          ch_cnt_d = ch_plus6[8:0];
        end
        // The beat is still taken; only the flag records the mismatch.
        if (s_axis_tlast != exp_tlast) tlast_err_d = 1'b1;
      end
      if (fifo_read) rows_read_d = rows_read_q + 12'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ics_q         <= '0;
      rows_q        <= '0;
      ch_cnt_q      <= '0;
      rows_loaded_q <= '0;
      rows_read_q   <= '0;
      tlast_err_q   <= 1'b0;
    end else begin
      ics_q         <= ics_d;
      rows_q        <= rows_d;
      ch_cnt_q      <= ch_cnt_d;
      rows_loaded_q <= rows_loaded_d;
      rows_read_q   <= rows_read_d;
      tlast_err_q   <= tlast_err_d;
    end
  end

endmodule

// File: tb/tb_axis_preload_ctrl.sv
module tb_axis_preload_ctrl;
  localparam int DEPTH = 4;
  localparam int P_IDLE = 0, P_CLEAR = 1, P_RUN = 2, P_DONE = 3, P_ABORT = 4;

  logic        clk = 1'b0;
  logic        rst, start, abort;
  logic [11:0] ics_in, rows_in;
  logic        tvalid, tlast, tready;
  logic [2:0]  fcnt;
  logic        full, empty;
  logic        load, rd, clr, mac_req, fire, busy, done, terr;

  always #5 clk = ~clk;

  axis_preload_ctrl #(.AXIS_PRELOAD_FIFO_DEPTH(DEPTH), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .input_channel_size(ics_in), .row_num(rows_in),
    .s_axis_tvalid(tvalid), .s_axis_tlast(tlast), .s_axis_tready(tready),
    .fifo_cnt(fcnt), .fifo_full(full), .fifo_empty(empty),
    .load_axis_preload(load), .fifo_read(rd), .axis_clear(clr),
    .mac_req(mac_req), .mac_row_fire(fire), .busy(busy), .done(done),
    .tlast_err(terr)
  );

  int total = 0, bad = 0;
  // Reference model: tile phase, beats/reads done, rows held by the FIFO.
  int m_ph = P_IDLE, m_ics = 0, m_rows = 0, m_beats = 0, m_reads = 0, f_cnt = 0;
  bit m_err = 1'b0;
  bit auto_tlast = 1'b1;
  int n_load, n_read, n_done, n_clear;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic clr_cnt();
    n_load = 0; n_read = 0; n_done = 0; n_clear = 0;
  endtask

  // One clock cycle: entered at a negedge with stimulus applied.
  task automatic cyc();
    int bpr, tot;
    bit e_rdy, e_ld, e_rd;
    bpr   = m_ics / 6 + 1;
    tot   = m_rows * bpr;
    fcnt  = 3'(f_cnt);
    full  = (f_cnt >= DEPTH);
    empty = (f_cnt == 0);
    if (auto_tlast) tlast = (m_beats == tot - 1);
    #1;
    e_rdy = (m_ph == P_RUN) && (m_beats / bpr < m_rows) && (f_cnt < DEPTH);
    e_ld  = tvalid && e_rdy;
    e_rd  = (m_ph == P_RUN) && mac_req && (f_cnt > 0) && (m_reads < m_rows);
    chk("tready", 32'(tready), 32'(e_rdy));
    chk("load",   32'(load),   32'(e_ld));
    chk("read",   32'(rd),     32'(e_rd));
    chk("fire",   32'(fire),   32'(e_rd));
    chk("clear",  32'(clr),    32'(m_ph == P_CLEAR || m_ph == P_ABORT));
    chk("busy",   32'(busy),   32'(m_ph != P_IDLE));
    chk("done",   32'(done),   32'(m_ph == P_DONE));
    chk("tlast_err", 32'(terr), 32'(m_err));
    n_load  += int'(load);
    n_read  += int'(rd);
    n_done  += int'(done);
    n_clear += int'(clr);
    @(posedge clk);
    if (e_ld) begin
      if (tlast !== (m_beats + 1 == tot)) m_err = 1'b1;
      m_beats++;
      if (m_beats % bpr == 0) f_cnt++;
    end
    if (e_rd) begin m_reads++; f_cnt--; end
    if (m_ph == P_CLEAR || m_ph == P_ABORT) f_cnt = 0;
    case (m_ph)
      P_IDLE: if (start) begin
        m_ics = int'(ics_in); m_rows = int'(rows_in);
        m_beats = 0; m_reads = 0; m_err = 1'b0; m_ph = P_CLEAR;
      end
      P_CLEAR: m_ph = abort ? P_ABORT : (m_rows == 0 ? P_DONE : P_RUN);
      P_RUN:   if (abort) m_ph = P_ABORT;
               else if (e_rd && m_reads == m_rows) m_ph = P_DONE;
      P_DONE:  m_ph = abort ? P_ABORT : P_IDLE;
      default: m_ph = P_IDLE;
    endcase
    @(negedge clk);
  endtask

  task automatic do_start(input int ics, input int rows);
    ics_in = 12'(ics); rows_in = 12'(rows); start = 1'b1;
    cyc();
    start = 1'b0;
    ics_in = 12'($urandom); rows_in = 12'($urandom);
  endtask

  task automatic run(input int max, input int vp, input int mp);
    for (int i = 0; i < max && m_ph != P_IDLE; i++) begin
      tvalid  = ($urandom % 100) < vp;
      mac_req = ($urandom % 100) < mp;
      cyc();
    end
    chk("tile_end_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; ics_in = '0; rows_in = '0;
    tvalid = 1'b0; tlast = 1'b0; mac_req = 1'b0;
    fcnt = '0; full = 1'b0; empty = 1'b1;
    @(negedge clk); #1;
    chk("rst_tready", 32'(tready), 0); chk("rst_load", 32'(load), 0);
    chk("rst_read", 32'(rd), 0);       chk("rst_fire", 32'(fire), 0);
    chk("rst_clear", 32'(clr), 0);     chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);     chk("rst_terr", 32'(terr), 0);
    @(negedge clk); rst = 1'b0;

    // ics=16 rows=2, stream and MAC always ready
    clr_cnt(); do_start(16, 2); run(200, 100, 100);
    chk("t1_loads", n_load, 6); chk("t1_reads", n_read, 2);
    chk("t1_done", n_done, 1);  chk("t1_clear", n_clear, 1);
    chk("t1_terr", 32'(terr), 0);

    // ics=5 rows=6: fills FIFO, stalls, one read reopens tready
    clr_cnt(); do_start(5, 6); tvalid = 1'b1; mac_req = 1'b0;
    repeat (8) cyc();
    chk("t2_fill_loads", n_load, 4);
    mac_req = 1'b1; cyc(); mac_req = 1'b0; cyc();
    chk("t2_one_read", n_read, 1); chk("t2_reopen_load", n_load, 5);
    run(200, 100, 100);
    chk("t2_loads", n_load, 6); chk("t2_reads", n_read, 6);
    chk("t2_done", n_done, 1);  chk("t2_terr", 32'(terr), 0);

    // rows=0: CLEAR then DONE, no traffic
    clr_cnt(); do_start(8, 0); run(20, 100, 100);
    chk("t3_loads", n_load, 0); chk("t3_reads", n_read, 0); chk("t3_done", n_done, 1);

    // ics=12 rows=1, tlast on beat 2 of 3
    clr_cnt(); do_start(12, 1); auto_tlast = 1'b0; tvalid = 1'b1; mac_req = 1'b0;
    tlast = 1'b0; cyc(); cyc(); tlast = 1'b1; cyc(); tlast = 1'b0; cyc();
    chk("t4_terr_set", 32'(terr), 1);
    auto_tlast = 1'b1; run(50, 100, 100);
    chk("t4_terr_sticky", 32'(terr), 1);
    do_start(16, 2);
    chk("t4_terr_clr", 32'(terr), 0);
    run(200, 100, 100);

    // abort on the 2nd beat of a 3-row tile
    clr_cnt(); do_start(12, 3); tvalid = 1'b1; mac_req = 1'b0;
    cyc(); cyc(); abort = 1'b1; cyc(); abort = 1'b0; cyc();
    chk("t5_busy", 32'(busy), 0); chk("t5_tready", 32'(tready), 0);
    chk("t5_done", n_done, 0);    chk("t5_clear", n_clear, 2);
    chk("t5_loads", n_load, 2);

    // start while busy is ignored
    clr_cnt(); do_start(16, 2); tvalid = 1'b1; mac_req = 1'b1;
    repeat (3) cyc();
    ics_in = 12'd5; rows_in = 12'd6; start = 1'b1; cyc(); start = 1'b0;
    run(200, 100, 100);
    chk("t6_loads", n_load, 6); chk("t6_reads", n_read, 2); chk("t6_done", n_done, 1);

    // randomized tiles, some with aborts and bad tlast
    for (int t = 0; t < 25; t++) begin
      bit ab, rt;
      int vp, mp;
      ab = (t % 5 == 4); rt = (t % 7 == 3);
      vp = int'($urandom_range(30, 100)); mp = int'($urandom_range(20, 100));
      clr_cnt(); do_start(int'($urandom_range(0, 40)), int'($urandom_range(0, 7)));
      for (int i = 0; i < 3000 && m_ph != P_IDLE; i++) begin
        tvalid  = ($urandom % 100) < vp;
        mac_req = ($urandom % 100) < mp;
        abort   = ab && ($urandom % 40 == 0);
        if (rt) begin auto_tlast = 1'b0; tlast = ($urandom % 4 == 0); end
        cyc();
      end
      abort = 1'b0; auto_tlast = 1'b1;
      chk("rnd_end_busy", 32'(busy), 0);
      chk("rnd_loads", n_load, m_beats);
      chk("rnd_reads", n_read, m_reads);
      chk("rnd_terr", 32'(terr), 32'(m_err));
    end

    // reset in the middle of a tile that already has a tlast error
    clr_cnt(); do_start(0, 3); auto_tlast = 1'b0; tvalid = 1'b1; mac_req = 1'b0;
    tlast = 1'b1; cyc(); cyc(); cyc();
    chk("t7_terr_pre", 32'(terr), 1);
    rst = 1'b1; #1;
    chk("t7_busy", 32'(busy), 0);   chk("t7_tready", 32'(tready), 0);
    chk("t7_clear", 32'(clr), 0);   chk("t7_terr", 32'(terr), 0);
    chk("t7_done", 32'(done), 0);
    m_ph = P_IDLE; f_cnt = 0; m_err = 1'b0; m_beats = 0; m_reads = 0;
    @(negedge clk); rst = 1'b0; auto_tlast = 1'b1;
    clr_cnt(); do_start(16, 2); run(200, 100, 100);
    chk("t7_after_loads", n_load, 6); chk("t7_after_done", n_done, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
